data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl_pkg.sv | 29 ++
 rtl/data_mem_ctrl_byte_lane_unit.sv | 55 +++++
 rtl/data_mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller: FSM states,
// access-size codes and the size/alignment legality helper.
package data_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDW,
    WR,
    DONE
  } state_t;

  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b011;
  localparam logic [2:0] SZ_WORD = 3'b111;

  localparam int SIGN_BIT = 3;

  // True when the size code is illegal or the low address bits misalign it.
  function automatic logic bad_size_or_align(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_byte_lane_unit.sv
// Combinational lane logic shared by loads and stores: extracts and extends a
// byte/half/word from a RAM word, and merges store data into a RAM word.
module byte_lane_unit
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [3:0]  sign_mask,
  input  logic [31:0] store_data,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        sign_ext;

  always_comb begin
    sign_ext = sign_mask[SIGN_BIT];
    sel_half = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase

    case (sign_mask[2:0])
      SZ_BYTE: load_val = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_val = {{16{sign_ext & sel_half[15]}}, sel_half};
      default: load_val = word;
    endcase
  end

  // Sub-word stores keep the untouched lanes of the word just read from RAM.
  always_comb begin
    store_word = word;
    case (sign_mask[2:0])
      SZ_BYTE: begin
        case (lane)
          2'd0:    store_word[7:0]   = store_data[7:0];
          2'd1:    store_word[15:8]  = store_data[7:0];
          2'd2:    store_word[23:16] = store_data[7:0];
          default: store_word[31:24] = store_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) store_word[31:16] = store_data[15:0];
        else         store_word[15:0]  = store_data[15:0];
      end
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: accepts CPU loads/stores, drives a single-port
// synchronous block RAM, and stalls the CPU while an access is in flight.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       addr,
  input  logic [31:0]       write_data,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [3:0]        sign_mask,
  output logic [31:0]       read_data,
  output logic              stall,
  output logic              access_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata
);

  // 33-bit compare so a window ending at the top of the address space works.
  localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (33'd4 << ADDR_W);

  state_t state, next_state;

  logic [ADDR_W-1:0] word_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  logic [3:0]        mask_q;
  logic              err_q;
  logic              store_q;

  logic        req;
  logic        accept;
  logic        req_err;
  logic        range_err;
  logic [31:0] load_val;
  logic [31:0] store_word;

  assign req       = memread | memwrite;
  assign accept    = (state == IDLE) && req;
  assign range_err = ({1'b0, addr} < {1'b0, BASE_ADDR}) || ({1'b0, addr} >= ADDR_LIMIT);
  assign req_err   = range_err || bad_size_or_align(sign_mask[2:0], addr[1:0]);

  byte_lane_unit lanes (
    .word       (ram_rdata),
    .lane       (lane_q),
    .sign_mask  (mask_q),
    .store_data (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      store_q <= 1'b0;
    end else if (accept) begin
      word_q  <= ADDR_W'((addr - BASE_ADDR) >> 2);
      lane_q  <= addr[1:0];
      wdata_q <= write_data;
      mask_q  <= sign_mask;
      err_q   <= req_err;
      store_q <= memwrite;
    end
  end

  // Rejected requests clear the load result; stores never touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data <= '0;
    end else if (accept && req_err) begin
      read_data <= '0;
    end else if (state == RDW && !store_q) begin
      read_data <= load_val;
    end
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    access_err = 1'b0;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) begin
          if (req_err)                                   next_state = DONE;
          else if (memwrite && sign_mask[2:0] == SZ_WORD) next_state = WR;
          else                                           next_state = RD;
        end
      end
      RD: begin
        stall      = 1'b1;
        ram_re     = 1'b1;
        ram_addr   = word_q;
        next_state = RDW;
      end
      RDW: begin
        stall      = 1'b1;
        next_state = DONE;
        if (store_q) begin
          ram_we    = 1'b1;
          ram_addr  = word_q;
          ram_wdata = store_word;
        end
      end
      WR: begin
        stall      = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = word_q;
        ram_wdata  = wdata_q;
        next_state = DONE;
      end
      DONE: begin
        access_err = err_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised self-checking bench for data_mem_ctrl: a transaction-level model
// predicts every cycle's outputs and the RAM contents, plus directed cases.
module tb_data_mem_ctrl;

  localparam int          ADDR_W = 10;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          WORDS  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic [31:0]       addr;
  logic [31:0]       write_data;
  logic              memwrite;
  logic              memread;
  logic [3:0]        sign_mask;
  logic [31:0]       read_data;
  logic              stall;
  logic              access_err;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [31:0]       ram_rdata;

  data_mem_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .sign_mask  (sign_mask),
    .read_data  (read_data),
    .stall      (stall),
    .access_err (access_err),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_rdata  (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural block RAM; the preload port is only used while in reset.
  logic [31:0]       mem [WORDS];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [31:0]       pre_data;

  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  typedef struct packed {
    logic              stall;
    logic              err;
    logic              re;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic [31:0]       rd;
  } exp_t;

  logic [31:0] ref_mem [WORDS];
  logic [31:0] model_rd;
  exp_t        exp_q[$];
  exp_t        cur;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One expectation per clock cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check_output("stall", 32'(stall), 32'(cur.stall));
      check_output("access_err", 32'(access_err), 32'(cur.err));
      check_output("ram_re", 32'(ram_re), 32'(cur.re));
      check_output("ram_we", 32'(ram_we), 32'(cur.we));
      check_output("read_data", read_data, cur.rd);
      if (cur.re || cur.we) check_output("ram_addr", 32'(ram_addr), 32'(cur.waddr));
      if (cur.we) check_output("ram_wdata", ram_wdata, cur.wdata);
    end
  end

  function automatic exp_t idle_exp();
    exp_t e;
    e    = '0;
    e.rd = model_rd;
    return e;
  endfunction

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(idle_exp());
      memread  = 1'b0;
      memwrite = 1'b0;
      addr     = $urandom;
      @(posedge clk); #1;
    end
  endtask

  // Issue one CPU request; the model decides the whole cycle-by-cycle outcome.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] m, input logic junk);
    exp_t        seq [4];
    int          cycles;
    int          n;
    int          idx;
    int          lane;
    logic        err;
    longint      off;
    logic [31:0] old_rd;
    logic [31:0] v;

    case (m[2:0])
      3'b001:  n = 1;
      3'b011:  n = 2;
      3'b111:  n = 4;
      default: n = 0;
    endcase
    off = longint'(a) - longint'(BASE);
    if (n == 0) err = 1'b1;
    else        err = (off < 0) || (off >= 4 * WORDS) || ((a % n) != 0);
    idx    = err ? 0 : int'(off / 4);
    lane   = int'(a % 4);
    old_rd = model_rd;
    for (int i = 0; i < 4; i++) seq[i] = idle_exp();
    seq[0].stall = 1'b1;

    if (err) begin
      cycles   = 2;
      seq[1].err = 1'b1;
      model_rd = 32'h0;
    end else if (wr && n == 4) begin
      cycles       = 3;
      seq[1].stall = 1'b1;
      seq[1].we    = 1'b1;
      seq[1].waddr = ADDR_W'(idx);
      seq[1].wdata = wd;
      ref_mem[idx] = wd;
    end else begin
      cycles       = 4;
      seq[1].stall = 1'b1;
      seq[1].re    = 1'b1;
      seq[1].waddr = ADDR_W'(idx);
      seq[2].stall = 1'b1;
      if (wr) begin
        v = ref_mem[idx];
        for (int b = 0; b < n; b++) v[8*(lane+b) +: 8] = wd[8*b +: 8];
        seq[2].we    = 1'b1;
        seq[2].waddr = ADDR_W'(idx);
        seq[2].wdata = v;
        ref_mem[idx] = v;
      end else begin
        v = ref_mem[idx] >> (8 * lane);
        if (n == 1) v = (m[3] && v[7])  ? (v | 32'hFFFF_FF00) : (v & 32'h0000_00FF);
        if (n == 2) v = (m[3] && v[15]) ? (v | 32'hFFFF_0000) : (v & 32'h0000_FFFF);
        model_rd = v;
      end
    end
    for (int i = 0; i < cycles; i++) seq[i].rd = old_rd;
    seq[cycles-1].rd = model_rd;

    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back(seq[i]);
      if (i < cycles - 1) begin
        memread = rd; memwrite = wr; addr = a; write_data = wd; sign_mask = m;
      end else if (junk) begin
        memread = 1'($urandom); memwrite = 1'($urandom);
        addr = $urandom; write_data = $urandom; sign_mask = 4'($urandom);
      end else begin
        memread = 1'b0; memwrite = 1'b0;
      end
      @(posedge clk); #1;
    end
    memread  = 1'b0;
    memwrite = 1'b0;
    if (!err && wr) check_output("ram_word", mem[idx], ref_mem[idx]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_read_data"}, read_data, 32'h0);
    check_output({tag, "_stall"}, 32'(stall), 32'h0);
    check_output({tag, "_access_err"}, 32'(access_err), 32'h0);
    check_output({tag, "_ram_we"}, 32'(ram_we), 32'h0);
    check_output({tag, "_ram_re"}, 32'(ram_re), 32'h0);
    check_output({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
    check_output({tag, "_ram_wdata"}, ram_wdata, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [2:0]  sizes [3];
  logic [31:0] r_addr;
  logic [3:0]  r_mask;
  logic [31:0] r_word;
  int          r_kind;
  int          r_n;
  logic [31:0] saved;

  initial begin
    sizes      = '{3'b001, 3'b011, 3'b111};
    rst_n      = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    addr       = '0;
    write_data = '0;
    sign_mask  = '0;
    pre_we     = 1'b0;
    pre_addr   = '0;
    pre_data   = '0;
    model_rd   = '0;
    @(posedge clk); #1;

    for (int i = 0; i < WORDS; i++) begin
      r_word     = (i == 5) ? 32'h80FF_7F01 : $urandom;
      pre_we     = 1'b1;
      pre_addr   = ADDR_W'(i);
      pre_data   = r_word;
      ref_mem[i] = r_word;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle_cycles(2);

    apply_stimulus(1'b1, 1'b0, BASE + 22, 32'h0, 4'b1001, 1'b0);
    check_output("signed_byte_load", read_data, 32'hFFFF_FFFF);
    apply_stimulus(1'b1, 1'b0, BASE + 22, 32'h0, 4'b0001, 1'b0);
    check_output("unsigned_byte_load", read_data, 32'h0000_00FF);

    apply_stimulus(1'b0, 1'b1, BASE + 22, 32'h0000_BEEF, 4'b0011, 1'b0);
    check_output("half_store_word5", mem[5], 32'hBEEF_7F01);

    apply_stimulus(1'b0, 1'b1, BASE, 32'hDEAD_BEEF, 4'b0111, 1'b0);
    apply_stimulus(1'b1, 1'b0, BASE, 32'h0, 4'b0111, 1'b0);
    check_output("word_store_load", read_data, 32'hDEAD_BEEF);

    apply_stimulus(1'b1, 1'b1, BASE + 4, 32'hFEED_F00D, 4'b0111, 1'b1);
    check_output("rw_both_read_data", read_data, 32'hDEAD_BEEF);
    check_output("rw_both_word1", mem[1], 32'hFEED_F00D);

    apply_stimulus(1'b1, 1'b0, BASE + 2, 32'h0, 4'b0111, 1'b0);
    check_output("misaligned_read_data", read_data, 32'h0);
    apply_stimulus(1'b1, 1'b0, BASE - 4, 32'h0, 4'b0111, 1'b0);
    check_output("below_base_read_data", read_data, 32'h0);
    idle_cycles(1);

    // Reset lands while a byte store is in its RAM read cycle.
    apply_stimulus(1'b1, 1'b0, BASE + 8, 32'h0, 4'b0111, 1'b0);
    saved = mem[7];
    exp_q.push_back(idle_exp());
    exp_q[0].stall = 1'b1;
    memread = 1'b0; memwrite = 1'b1; addr = BASE + 29; write_data = 32'h0000_00AA;
    sign_mask = 4'b0001;
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst_n    = 1'b0;
    memwrite = 1'b0;
    #1;
    exp_q.delete();
    model_rd = 32'h0;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    check_output("midreset_word7", mem[7], saved);
    idle_cycles(2);

    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 99) < 5) r_mask = 4'($urandom);
      else r_mask = {1'($urandom), sizes[$urandom_range(0, 2)]};
      r_kind = $urandom_range(0, 99);
      if (r_kind < 5)       r_addr = BASE - 32'($urandom_range(1, 16));
      else if (r_kind < 10) r_addr = BASE + 32'(4 * WORDS) + 32'($urandom_range(0, 15));
      else                  r_addr = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
      r_n = (r_mask[2:0] == 3'b111) ? 4 : (r_mask[2:0] == 3'b011) ? 2 : 1;
      if ($urandom_range(0, 99) < 75) r_addr = r_addr & ~32'(r_n - 1);
      r_kind = $urandom_range(0, 2);
      apply_stimulus(r_kind != 1, r_kind != 0, r_addr, $urandom, r_mask, 1'($urandom));
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
